inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Hardware program loader for rooth_soc; the synthesizable writer side of instruction-memory preload.
- Accepts a framed byte stream (e.g. from a UART RX) over valid/ready and writes 32-bit little-endian words into inst_mem from word address 0.
- Holds the rooth core in reset while loading and releases it after a frame with a good checksum.

Parameters:
- ADDR_WIDTH, 12, inst_mem word-address width; DEPTH = 2**ADDR_WIDTH words.
- TIMEOUT_CYC, 65535, maximum idle cycles between accepted bytes inside a frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load_start  input  1  one-cycle pulse; begins a frame; honoured only in IDLE/DONE/ERR
- rx_valid  input  1  byte valid
- rx_data  input  8  byte
- rx_ready  output  1  byte accepted when rx_valid && rx_ready
- im_we  output  1  inst_mem write strobe, one cycle per word
- im_waddr  output  ADDR_WIDTH  word address
- im_wdata  output  `CPU_WIDTH  word data
- core_rst_n  output  1  registered reset to rooth core, active low
- busy  output  1  frame in progress
- done  output  1  last frame loaded OK (sticky)
- err  output  1  last frame failed (sticky)

Behaviour:
- Interface: one clock clk; reset rst_n asynchronous, active-low. All state resets to IDLE.
- Reset values: rx_ready=0, im_we=0, im_waddr=0, im_wdata=0, core_rst_n=0, busy=0, done=0, err=0.
- Frame format:
  - 4-byte word count N, little-endian.
  - 4*N data bytes; word k = {b3,b2,b1,b0}.
  - 1 checksum byte = XOR of all data bytes (length bytes excluded).
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + load_start -> LEN.
  - Clear byte index, word counter, checksum, and done/err.
  - busy=1 from the next cycle.
- LEN: accept 4 bytes.
  - After the 4th byte: N > DEPTH -> ERR; N == 0 -> CSUM; else -> DATA.
- DATA: shift bytes into the word register and XOR each into the checksum.
  - On the 4th byte of a word, im_we=1 the next cycle, with im_waddr = word counter and im_wdata = the assembled word.
  - The word counter then increments.
  - After word N-1 is written -> CSUM.
- CSUM: accept 1 byte.
  - Equal to the checksum -> DONE (done=1); otherwise -> ERR (err=1).
  - No rollback of memory already written.
- rx_ready = 1 only in LEN/DATA/CSUM. The byte presented in the same cycle as load_start is not accepted.
- load_start while busy: ignored.
- Timeout: a counter in LEN/DATA/CSUM reloads on each accepted byte. Reaching TIMEOUT_CYC cycles with no accepted byte -> ERR.
- core_rst_n:
  - Registered, one cycle after the state decode; 0 in LEN/DATA/CSUM/ERR, 1 in IDLE/DONE.
  - After rst_n release: 0 for one cycle, then 1 in IDLE, so the core boots the existing memory image.
- busy = 1 exactly in LEN/DATA/CSUM.
- Reset mid-frame: everything returns to reset values immediately. Partial memory contents are not cleared.
- Word counter is ADDR_WIDTH+1 bits wide so that N == DEPTH is legal; im_waddr takes its low bits.

Decomposition:
- State encodings (LOADER_IDLE etc.), the frame length-byte count, and `CPU_WIDTH go in rooth_defines.v.
- Sub-module inst_loader_timer: reloadable down-counter.
  - Inputs: clk, rst_n, enable, reload.
  - Output: expire pulse.

Test Plan:
- 2-word frame: load_start, then bytes 02 00 00 00 93 00 00 00 13 01 10 00 91.
  - Response: im_we pulses at addr 0 with 0x00000093 and at addr 1 with 0x00100113; done=1, err=0; core_rst_n low during the frame, high one cycle after DONE.
- Same frame with checksum 0x90 -> err=1, done=0, core_rst_n held 0; a new load_start plus the correct frame -> done=1.
- Zero length: bytes 00 00 00 00 00 -> no im_we, done=1.
- Oversize: length 01 10 00 00 (0x1001) with ADDR_WIDTH=12 -> ERR after the 4th byte, no im_we, rx_ready=0.
- Timeout with TIMEOUT_CYC=16: stop after 6 data bytes -> err=1 16 cycles after the last accepted byte; only word 0 written.
- rst_n asserted mid-DATA -> all outputs at reset values in the same cycle; after release core_rst_n returns to 1 and busy=0.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared types and constants for the instruction-memory loader
package inst_loader_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int LEN_BYTES = 4;

  typedef enum logic [2:0] {
    LOADER_IDLE = 3'd0,
    LOADER_LEN  = 3'd1,
    LOADER_DATA = 3'd2,
    LOADER_CSUM = 3'd3,
    LOADER_DONE = 3'd4,
    LOADER_ERR  = 3'd5
  } loader_state_e;

  function automatic logic is_active(loader_state_e s);
    return (s == LOADER_LEN) || (s == LOADER_DATA) || (s == LOADER_CSUM);
  endfunction

endpackage

// File: rtl/inst_loader_timer.sv
// rtl/inst_loader_timer.sv - reloadable down-counter flagging an idle gap of TIMEOUT_CYC cycles
module inst_loader_timer #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic reload,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] RELOAD_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at the reload value while disabled so every frame starts with a full budget.
  always_comb begin
    cnt_d = cnt_q;
    if (reload || !enable) begin
      cnt_d = RELOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && !reload && (cnt_q == '0);

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - framed byte-stream loader writing little-endian words into inst_mem
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_waddr,
  output logic [CPU_WIDTH-1:0]  im_wdata,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int WCW   = ADDR_WIDTH + 1;

  loader_state_e         state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [CPU_WIDTH-1:0]  word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic [WCW-1:0]        nwords_q, nwords_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  im_we_q, im_we_d;
  logic [ADDR_WIDTH-1:0] im_waddr_q, im_waddr_d;
  logic [CPU_WIDTH-1:0]  im_wdata_q, im_wdata_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  timeout;
  logic [CPU_WIDTH-1:0]  shifted;
  logic [WCW-1:0]        wcnt_inc;

  assign accept   = rx_valid && rx_ready_q;
  // Bytes enter at the top so that after four shifts byte 0 sits in bits [7:0].
  assign shifted  = {rx_data, word_q[CPU_WIDTH-1:8]};
  assign wcnt_inc = wcnt_q + WCW'(1);

  inst_loader_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (is_active(state_q)),
    .reload (accept),
    .expire (timeout)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    wcnt_d       = wcnt_q;
    nwords_d     = nwords_q;
    im_we_d      = 1'b0;
    im_waddr_d   = im_waddr_q;
    im_wdata_d   = im_wdata_q;
    done_d       = done_q;
    err_d        = err_q;

    case (state_q)
      LOADER_IDLE, LOADER_DONE, LOADER_ERR: begin
        if (load_start) begin
          state_d = LOADER_LEN;
          idx_d   = 2'd0;
          wcnt_d  = '0;
          csum_d  = 8'h00;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      LOADER_LEN: begin
        if (accept) begin
          word_d = shifted;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'(LEN_BYTES - 1)) begin
            nwords_d = shifted[WCW-1:0];
            if (shifted > 32'(DEPTH)) begin
              state_d = LOADER_ERR;
              err_d   = 1'b1;
            end else if (shifted == '0) begin
              state_d = LOADER_CSUM;
            end else begin
              state_d = LOADER_DATA;
            end
          end
        end
      end
      LOADER_DATA: begin
        if (accept) begin
          word_d = shifted;
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            im_we_d    = 1'b1;
            im_waddr_d = wcnt_q[ADDR_WIDTH-1:0];
            im_wdata_d = shifted;
            wcnt_d     = wcnt_inc;
            if (wcnt_inc == nwords_q) begin
              state_d = LOADER_CSUM;
            end
          end
        end
      end
      LOADER_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = LOADER_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOADER_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = LOADER_IDLE;
      end
    endcase

    // Expiry only fires without an accepted byte, so it never races a data-path update.
    if (timeout) begin
      state_d = LOADER_ERR;
      err_d   = 1'b1;
    end

    rx_ready_d   = is_active(state_d);
    busy_d       = is_active(state_d);
    core_rst_n_d = (state_q == LOADER_IDLE) || (state_q == LOADER_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOADER_IDLE;
      idx_q        <= 2'd0;
      word_q       <= '0;
      csum_q       <= 8'h00;
      wcnt_q       <= '0;
      nwords_q     <= '0;
      rx_ready_q   <= 1'b0;
      im_we_q      <= 1'b0;
      im_waddr_q   <= '0;
      im_wdata_q   <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      wcnt_q       <= wcnt_d;
      nwords_q     <= nwords_d;
      rx_ready_q   <= rx_ready_d;
      im_we_q      <= im_we_d;
      im_waddr_q   <= im_waddr_d;
      im_wdata_q   <= im_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign im_we      = im_we_q;
  assign im_waddr   = im_waddr_q;
  assign im_wdata   = im_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed scoreboard bench for inst_loader
module tb_inst_loader;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t        sb[$];
  wr_t        got_w;
  logic [7:0] tb_csum;

  always #5 clk = ~clk;

  inst_loader #(
    .ADDR_WIDTH  (AW),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (im_we) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed %0h at %0h expected no write", im_wdata, im_waddr);
      end
      if (sb.size() != 0) begin
        got_w = sb.pop_front();
        chk("im_waddr", 32'(im_waddr), 32'(got_w.a));
        chk("im_wdata", im_wdata, got_w.d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    chk("byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    sb.push_back(w);
    for (int i = 0; i < 4; i++) begin
      tb_csum = tb_csum ^ d[8*i +: 8];
      send_byte(d[8*i +: 8]);
    end
  endtask

  task automatic start_frame();
    load_start = 1'b1;
    rx_valid   = 1'b1;
    rx_data    = 8'hAA;
    #1;
    chk("rx_ready_with_start", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    tb_csum    = 8'h00;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_cleared", 32'(done), 32'd0);
    chk("err_cleared", 32'(err), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_im_we"}, 32'(im_we), 32'd0);
    chk({tag, "_im_waddr"}, 32'(im_waddr), 32'd0);
    chk({tag, "_im_wdata"}, im_wdata, 32'd0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic good_two_word_frame();
    start_frame();
    send_len(32'd2);
    send_word(12'd0, 32'h0000_0093);
    send_word(12'd1, 32'h0010_0113);
    chk("csum_model", 32'(tb_csum), 32'h91);
    send_byte(tb_csum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("core_rst_n_first_cycle", 32'(core_rst_n), 32'd0);
    @(posedge clk);
    #1 chk("core_rst_n_boot", 32'(core_rst_n), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);

    // Two-word frame with an ignored load_start in the middle.
    start_frame();
    send_len(32'd2);
    chk("core_rst_n_in_frame", 32'(core_rst_n), 32'd0);
    load_start = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
    chk("busy_ignore_start", 32'(busy), 32'd1);
    send_word(12'd0, 32'h0000_0093);
    send_word(12'd1, 32'h0010_0113);
    send_byte(8'h91);
    chk("f1_done", 32'(done), 32'd1);
    chk("f1_err", 32'(err), 32'd0);
    chk("f1_busy", 32'(busy), 32'd0);
    chk("f1_rx_ready", 32'(rx_ready), 32'd0);
    chk("f1_core_rst_n_lag", 32'(core_rst_n), 32'd0);
    @(posedge clk);
    #1 chk("f1_core_rst_n_release", 32'(core_rst_n), 32'd1);
    chk("f1_sb_drained", sb.size(), 32'd0);

    // Bad checksum, then recovery with the correct frame.
    start_frame();
    send_len(32'd2);
    send_word(12'd0, 32'h0000_0093);
    send_word(12'd1, 32'h0010_0113);
    send_byte(8'h90);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("bad_core_rst_n_held", 32'(core_rst_n), 32'd0);
    good_two_word_frame();
    chk("retry_done", 32'(done), 32'd1);
    chk("retry_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("retry_sb_drained", sb.size(), 32'd0);

    // Zero-length frame.
    start_frame();
    send_len(32'd0);
    send_byte(8'h00);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_err", 32'(err), 32'd0);

    // Oversize length.
    start_frame();
    send_len(32'h0000_1001);
    chk("over_err", 32'(err), 32'd1);
    chk("over_rx_ready", 32'(rx_ready), 32'd0);
    chk("over_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("over_done", 32'(done), 32'd0);

    // Timeout after six data bytes.
    start_frame();
    send_len(32'd2);
    send_word(12'd0, 32'hDEAD_BEEF);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (15) @(posedge clk);
    #1 chk("to_err_before", 32'(err), 32'd0);
    chk("to_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1 chk("to_err_at", 32'(err), 32'd1);
    chk("to_busy_at", 32'(busy), 32'd0);
    chk("to_sb_drained", sb.size(), 32'd0);

    // Asynchronous reset mid-DATA.
    start_frame();
    send_len(32'd1);
    send_byte(8'hAA);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("midreset_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
